ha_array_mul_seq_ctrl: RTL and testbench
========================================

Name: ha_array_mul_seq_ctrl

Overview:
- Sequencing controller for the 8x8 unsigned approximate multiplier's half-adder partial-product array (4 row pairs, each a 9-bit t vector and a 7-bit b vector).
- Accepts operand pairs over valid/ready and registers them onto the array inputs.
- Reduces the four array rows into a 16-bit product, one row per cycle, through a single shared adder.
- Returns the product over valid/ready. This is the time-multiplexed, area-lean alternative to a full compressor tree behind the array.

Parameters:
- NUM_ROWS, 4, number of HA row pairs; the row counter wraps at NUM_ROWS-1.
- ROW_SHIFT, 2, bit weight step between consecutive rows; row k is weighted by 2^(ROW_SHIFT*k).
- PROD_W, 16, product output width.
- COMP_BIAS, 16'd0, bias compensation constant; used only when ERR_COMP_EN is defined.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  controller can accept operands.
- x  input  8  multiplicand.
- y  input  8  multiplier.
- mul_x  output  8  registered x, drives the array's x.
- mul_y  output  8  registered y, drives the array's y.
- ha_array_0_t..ha_array_3_t  input  9 each  array t vectors (4 ports).
- ha_array_0_b..ha_array_3_b  input  7 each  array b vectors (4 ports).
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts the product.
- product  output  PROD_W  approximate product.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state goes to IDLE.
  - mul_x, mul_y, the accumulator, product, out_valid, busy and the row counter all go to 0.
  - in_ready goes to 1 once rst_n is high.
  - No partial result survives reset.
- Row value: row_k = t_k + (b_k << 2), 10 bits. Contribution is row_k << (ROW_SHIFT*k). The accumulator is PROD_W+1 bits.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: capture x→mul_x and y→mul_y, clear the accumulator, set row=0, go to ACC.
- ACC:
  - in_ready=0.
  - Each cycle: acc += row_row << (2*row), using the array outputs combinationally; the array settles from mul_x/mul_y registered in the previous cycle.
  - If row==NUM_ROWS-1, go to DONE (or COMP when ERR_COMP_EN is defined); otherwise row++.
- DONE:
  - out_valid=1.
  - product = saturate(acc): 0xFFFF if acc[PROD_W] is set, otherwise acc[PROD_W-1:0].
  - product and out_valid hold stable while out_ready=0.
  - On out_ready: out_valid drops next cycle, go to IDLE.
  - No back-to-back acceptance: in_ready stays 0 until IDLE.
- Latency: handshake edge at cycle 0, rows accumulated at edges 1..4, out_valid high from edge 4 (visible in cycle 5).
- Throughput: at most one operation per 6 cycles when out_ready is held high.
- in_valid is ignored outside IDLE. x and y may change freely after acceptance.
- mul_x/mul_y hold their value until the next acceptance; they are not cleared in DONE.
- product is 0 outside DONE.

Optional Feature:
- Macro ERR_COMP_EN.
- Defined:
  - Extra state COMP between ACC and DONE.
  - COMP: acc += COMP_BIAS, with the same saturation applied at DONE.
  - Latency is +1 cycle.
- Undefined:
  - No COMP state; ACC goes directly to DONE.
  - COMP_BIAS is ignored. Latency is as above.

Test Plan:
- Reset/idle: assert rst_n=0 mid-ACC (after row 1) → state IDLE; out_valid=0, product=0, busy=0; in_ready=1 after release; next operation x=1, y=1 with real array → product=1.
- Stubbed array, all t=9'h001, b=0, x=3, y=5 → mul_x=3, mul_y=5; product=85 (1+4+16+64); out_valid in cycle 5 after the handshake.
- Stubbed array, row2 only: t=9'h010, b=7'h01, others 0 → product=(16+4)<<4=320.
- Saturation: stub all t=9'h1FF, b=7'h7F (row=1019, sum 86615) → product=16'hFFFF.
- Backpressure: out_ready=0 for 10 cycles after out_valid → product and out_valid stable; in_valid pulsed meanwhile is not accepted (in_ready=0); out_ready=1 → IDLE next cycle.
- ERR_COMP_EN defined, COMP_BIAS=30, zero array stub → product=30, out_valid one cycle later than without the macro; with the saturation stub, product=16'hFFFF.

Source files
------------

// File: rtl/ha_array_mul_seq_ctrl.sv
// ha_array_mul_seq_ctrl
// Sequencing controller behind the 8x8 approximate multiplier's half-adder
// partial-product array. It registers an operand pair onto the array inputs.
// It then folds the four t/b row pairs into a saturating accumulator, one row
// per cycle, using a single shared adder. The product is returned over
// valid/ready.
//
// Optional build macro: ERR_COMP_EN
//   defined   -> an extra COMP state adds COMP_BIAS to the accumulator
//                before DONE (one extra cycle of latency)
//   undefined -> ACC goes straight to DONE; COMP_BIAS has no effect
module ha_array_mul_seq_ctrl #(
   parameter int                NUM_ROWS  = 4,
   parameter int                ROW_SHIFT = 2,
   parameter int                PROD_W    = 16,
   parameter logic [PROD_W-1:0] COMP_BIAS = 16'd0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        x,
   input  logic [7:0]        y,
   output logic [7:0]        mul_x,
   output logic [7:0]        mul_y,
   input  logic [8:0]        ha_array_0_t,
   input  logic [8:0]        ha_array_1_t,
   input  logic [8:0]        ha_array_2_t,
   input  logic [8:0]        ha_array_3_t,
   input  logic [6:0]        ha_array_0_b,
   input  logic [6:0]        ha_array_1_b,
   input  logic [6:0]        ha_array_2_b,
   input  logic [6:0]        ha_array_3_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] product,
   output logic              busy
);

   localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam int ACC_W = PROD_W + 1;
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

   // COMP is always encoded so that a corrupted state register still lands
   // on a decoded state; it is only entered when ERR_COMP_EN is defined.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_COMP = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t             state_r;
   state_t             state_s;
   logic [ROW_W-1:0]   row_r;
   logic [ROW_W-1:0]   row_s;
   logic [ACC_W-1:0]   acc_r;
   logic [ACC_W-1:0]   acc_s;
   logic               accept_s;
   logic [7:0]         mul_x_r;
   logic [7:0]         mul_y_r;
   logic               in_ready_r;
   logic               busy_r;
   logic               out_valid_r;
   logic [PROD_W-1:0]  product_r;

   logic [8:0]         t_sel_s;
   logic [6:0]         b_sel_s;
   logic [9:0]         row_val_s;
   logic [ACC_W-1:0]   contrib_s;
   logic [ACC_W-1:0]   acc_add_s;
   logic [ACC_W-1:0]   acc_bias_s;

   // Add two accumulator-width values, pinning to all-ones on carry-out so a
   // large sum can never wrap back to a small product.
   function automatic logic [ACC_W-1:0] add_sat(input logic [ACC_W-1:0] a,
                                                input logic [ACC_W-1:0] b);
      logic [ACC_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
   endfunction

   // Clamp the accumulator to the product width.
   function automatic logic [PROD_W-1:0] sat_product(input logic [ACC_W-1:0] a);
      return a[PROD_W] ? {PROD_W{1'b1}} : a[PROD_W-1:0];
   endfunction

   // Select the t/b pair of the row currently being reduced.
   always_comb begin
      t_sel_s = 9'd0;
      b_sel_s = 7'd0;
      case (row_r)
         ROW_W'(0): begin
            t_sel_s = ha_array_0_t;
            b_sel_s = ha_array_0_b;
         end
         ROW_W'(1): begin
            t_sel_s = ha_array_1_t;
            b_sel_s = ha_array_1_b;
         end
         ROW_W'(2): begin
            t_sel_s = ha_array_2_t;
            b_sel_s = ha_array_2_b;
         end
         ROW_W'(3): begin
            t_sel_s = ha_array_3_t;
            b_sel_s = ha_array_3_b;
         end
         default: begin
            t_sel_s = 9'd0;
            b_sel_s = 7'd0;
         end
      endcase
   end

   // Shared adder path: weight the row value and form both candidate sums.
   always_comb begin
      row_val_s  = {1'b0, t_sel_s} + {1'b0, b_sel_s, 2'b00};
      contrib_s  = ACC_W'(row_val_s) << (ROW_SHIFT * int'(row_r));
      acc_add_s  = add_sat(acc_r, contrib_s);
      acc_bias_s = add_sat(acc_r, {1'b0, COMP_BIAS});
   end

   // Next-state, next-row and next-accumulator decode.
   always_comb begin
      state_s  = state_r;
      row_s    = row_r;
      acc_s    = acc_r;
      accept_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (in_valid && in_ready_r) begin
               accept_s = 1'b1;
               acc_s    = {ACC_W{1'b0}};
               row_s    = {ROW_W{1'b0}};
               state_s  = ST_ACC;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_ACC: begin
            acc_s = acc_add_s;
            if (row_r == LAST_ROW) begin
               row_s = {ROW_W{1'b0}};
`ifdef ERR_COMP_EN
               state_s = ST_COMP;
`else
               state_s = ST_DONE;
`endif
            end else begin
               row_s = row_r + ROW_W'(1);
            end
         end
         ST_COMP: begin
            acc_s   = acc_bias_s;
            state_s = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_DONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
            row_s   = {ROW_W{1'b0}};
            acc_s   = {ACC_W{1'b0}};
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Datapath registers and registered handshake/status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_r       <= {ROW_W{1'b0}};
         acc_r       <= {ACC_W{1'b0}};
         mul_x_r     <= 8'd0;
         mul_y_r     <= 8'd0;
         in_ready_r  <= 1'b0;
         busy_r      <= 1'b0;
         out_valid_r <= 1'b0;
         product_r   <= {PROD_W{1'b0}};
      end else begin
         row_r <= row_s;
         acc_r <= acc_s;
         if (accept_s) begin
            mul_x_r <= x;
            mul_y_r <= y;
         end else begin
            mul_x_r <= mul_x_r;
            mul_y_r <= mul_y_r;
         end
         in_ready_r  <= (state_s == ST_IDLE);
         busy_r      <= (state_s != ST_IDLE);
         out_valid_r <= (state_s == ST_DONE);
         product_r   <= (state_s == ST_DONE) ? sat_product(acc_s) : {PROD_W{1'b0}};
      end
   end

   assign mul_x     = mul_x_r;
   assign mul_y     = mul_y_r;
   assign in_ready  = in_ready_r;
   assign busy      = busy_r;
   assign out_valid = out_valid_r;
   assign product   = product_r;

endmodule

// File: tb/tb_ha_array_mul_seq_ctrl.sv
// Self-checking bench for ha_array_mul_seq_ctrl. The HA array is replaced by
// either constant stubs or a behavioural model that presents exact partial
// products (row k = mul_x * mul_y[2k+1:2k], split into t + 4*b).
module tb_ha_array_mul_seq_ctrl;

`ifdef ERR_COMP_EN
   localparam int TB_BIAS = 30;
   localparam int LAT     = 5;
`else
   localparam int TB_BIAS = 0;
   localparam int LAT     = 4;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  x;
   logic [7:0]  y;
   logic [7:0]  mul_x;
   logic [7:0]  mul_y;
   logic [8:0]  ha_t [4];
   logic [6:0]  ha_b [4];
   logic        out_valid;
   logic        out_ready;
   logic [15:0] product;
   logic        busy;

   logic        use_model;
   logic [35:0] stub_t_all;
   logic [27:0] stub_b_all;

   int n_tests = 0;
   int n_fail  = 0;
   logic [15:0] sb_q [$];

   typedef struct packed {
      logic        model;
      logic [7:0]  x;
      logic [7:0]  y;
      logic [35:0] t_all;
      logic [27:0] b_all;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs [10];

   ha_array_mul_seq_ctrl #(
      .NUM_ROWS (4),
      .ROW_SHIFT(2),
      .PROD_W   (16),
      .COMP_BIAS(16'(TB_BIAS))
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .x           (x),
      .y           (y),
      .mul_x       (mul_x),
      .mul_y       (mul_y),
      .ha_array_0_t(ha_t[0]),
      .ha_array_1_t(ha_t[1]),
      .ha_array_2_t(ha_t[2]),
      .ha_array_3_t(ha_t[3]),
      .ha_array_0_b(ha_b[0]),
      .ha_array_1_b(ha_b[1]),
      .ha_array_2_b(ha_b[2]),
      .ha_array_3_b(ha_b[3]),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .product     (product),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Array stand-in: constant stubs or exact partial products from mul_x/mul_y.
   always_comb begin
      logic [9:0] pp;
      logic [9:0] bb;
      logic [9:0] tt;
      pp = 10'd0;
      bb = 10'd0;
      tt = 10'd0;
      for (int k = 0; k < 4; k++) begin
         pp = {2'b00, mul_x} * {8'b0, mul_y[2*k +: 2]};
         bb = ((pp >> 2) > 10'd127) ? 10'd127 : (pp >> 2);
         tt = pp - (bb << 2);
         if (use_model) begin
            ha_t[k] = tt[8:0];
            ha_b[k] = bb[6:0];
         end else begin
            ha_t[k] = stub_t_all[9*k +: 9];
            ha_b[k] = stub_b_all[7*k +: 7];
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic logic [15:0] with_bias(input logic [15:0] p);
      logic [17:0] s;
      s = {2'b00, p} + 18'(TB_BIAS);
      return (s > 18'd65535) ? 16'hFFFF : s[15:0];
   endfunction

   // One complete operation: handshake, latency, optional backpressure, drain.
   task automatic run_op(input vec_t v, input int hold, input logic pulse);
      int          cyc;
      logic [15:0] held;
      logic [15:0] exp_p;
      use_model  = v.model;
      stub_t_all = v.t_all;
      stub_b_all = v.b_all;
      cyc = 0;
      while (!in_ready && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("in_ready_before_op", {31'd0, in_ready}, 32'd1);
      x        = v.x;
      y        = v.y;
      in_valid = 1'b1;
      sb_q.push_back(with_bias(v.exp));
      @(posedge clk); #1;
      in_valid = 1'b0;
      x = ~v.x;
      y = ~v.y;
      check("mul_x_capture", {24'd0, mul_x}, {24'd0, v.x});
      check("mul_y_capture", {24'd0, mul_y}, {24'd0, v.y});
      check("busy_in_acc", {31'd0, busy}, 32'd1);
      check("in_ready_in_acc", {31'd0, in_ready}, 32'd0);
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!out_valid && cyc < 20);
      check("latency", 32'(cyc), 32'(LAT));
      held = product;
      for (int i = 0; i < hold; i++) begin
         if (pulse) begin
            in_valid = 1'b1;
            x = 8'h5A;
            y = 8'hA5;
         end
         @(posedge clk); #1;
         check("bp_out_valid", {31'd0, out_valid}, 32'd1);
         check("bp_product", {16'd0, product}, {16'd0, held});
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      if (sb_q.size() > 0) begin
         exp_p = sb_q.pop_front();
         check("product", {16'd0, product}, {16'd0, exp_p});
      end else begin
         check("scoreboard_empty", 32'd1, 32'd0);
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("drain_out_valid", {31'd0, out_valid}, 32'd0);
      check("drain_product", {16'd0, product}, 32'd0);
      check("drain_busy", {31'd0, busy}, 32'd0);
      check("drain_in_ready", {31'd0, in_ready}, 32'd1);
      if (pulse) begin
         check("bp_mul_x_kept", {24'd0, mul_x}, {24'd0, v.x});
      end
   endtask

   initial begin
      vecs[0] = '{1'b0, 8'd3,   8'd5,   {9'h001, 9'h001, 9'h001, 9'h001}, 28'd0,                              16'd85};
      vecs[1] = '{1'b0, 8'd7,   8'd9,   {9'h000, 9'h010, 9'h000, 9'h000}, {7'h00, 7'h01, 7'h00, 7'h00},       16'd320};
      vecs[2] = '{1'b0, 8'd1,   8'd1,   {9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF}, {7'h7F, 7'h7F, 7'h7F, 7'h7F},       16'hFFFF};
      vecs[3] = '{1'b0, 8'd2,   8'd2,   36'd0,                            28'd0,                              16'd0};
      vecs[4] = '{1'b0, 8'd0,   8'd0,   {9'h001, 9'h000, 9'h000, 9'h000}, 28'd0,                              16'd64};
      vecs[5] = '{1'b0, 8'd0,   8'd0,   36'd0,                            {7'h00, 7'h00, 7'h7F, 7'h00},       16'd2032};
      vecs[6] = '{1'b1, 8'd1,   8'd1,   36'd0,                            28'd0,                              16'd1};
      vecs[7] = '{1'b1, 8'd255, 8'd255, 36'd0,                            28'd0,                              16'd65025};
      vecs[8] = '{1'b1, 8'hA5,  8'h3C,  36'd0,                            28'd0,                              16'd9900};
      vecs[9] = '{1'b1, 8'd17,  8'd200, 36'd0,                            28'd0,                              16'd3400};

      rst_n      = 1'b0;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      x          = 8'd0;
      y          = 8'd0;
      use_model  = 1'b1;
      stub_t_all = 36'd0;
      stub_b_all = 28'd0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_product", {16'd0, product}, 32'd0);
      check("rst_mul_x", {24'd0, mul_x}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_release_in_ready", {31'd0, in_ready}, 32'd1);

      // Table-driven operations.
      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i], 0, 1'b0);
      end

      // Backpressure: hold out_ready low for 10 cycles while pulsing in_valid.
      run_op(vecs[8], 10, 1'b1);

      // Reset mid-ACC after rows 0 and 1 have been accumulated.
      use_model = 1'b1;
      x         = 8'd3;
      y         = 8'd5;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("midacc_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      sb_q.delete();
      check("midacc_rst_busy", {31'd0, busy}, 32'd0);
      check("midacc_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midacc_rst_product", {16'd0, product}, 32'd0);
      check("midacc_rst_mul_x", {24'd0, mul_x}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("midacc_release_in_ready", {31'd0, in_ready}, 32'd1);
      run_op(vecs[6], 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
